// File: rtl/ring_node.sv
`default_nettype none
// =====================================================================
// Module   : ring_node
// Purpose  : Unidirectional-ring endpoint for one PU: local injection
//            FIFO, single-entry forward slot, local delivery to pu_rx.
// Options  : define RING_DROP_CNT_EN to add the 8-bit drop_cnt port.
// Revision : 1.0  initial release
// =====================================================================
module ring_node #(
  parameter int unsigned NODE       = 0,
  parameter int unsigned PKT_W      = 20,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PKT_W-1:0] pu_tx,
  output logic [PKT_W-1:0] pu_rx,
  input  logic [PKT_W-1:0] ring_in,
  output logic             ring_in_rdy,
  output logic [PKT_W-1:0] ring_out,
  input  logic             ring_out_rdy,
  output logic             fifo_full
`ifdef RING_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  localparam int unsigned c_addr_w   = $clog2(FIFO_DEPTH);
  localparam int unsigned c_ptr_w    = c_addr_w + 1;
  localparam int unsigned c_starve_w = $clog2(STARVE_LIM + 1);
  localparam logic [1:0]  c_node     = 2'(NODE);
  localparam logic [c_starve_w-1:0] c_starve_lim = c_starve_w'(STARVE_LIM);

  logic [PKT_W-1:0]      pu_rx_q, pu_rx_d;
  logic [PKT_W-1:0]      ring_out_q, ring_out_d;
  logic [PKT_W-1:0]      fifo_mem_q [FIFO_DEPTH];
  logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]    rd_ptr_q, rd_ptr_d;
  logic                  fifo_full_q, fifo_full_d;
  logic [c_starve_w-1:0] starve_q, starve_d;

  logic             w_out_v;
  logic             w_slot_free;
  logic             w_yield;
  logic             w_fifo_empty;
  logic [PKT_W-1:0] w_head;
  logic             w_head_local;
  logic             w_head_remote;
  logic             w_ring_acc;
  logic             w_ring_deliver;
  logic             w_ring_load;
  logic             w_head_deliver;
  logic             w_head_inject;
  logic             w_pop;
  logic             w_push;

  assign w_out_v      = ring_out_q[PKT_W-1];
  assign w_slot_free  = !w_out_v || ring_out_rdy;
  assign w_yield      = (starve_q == c_starve_lim);
  // Held low during reset so nothing upstream hands off into a node being cleared.
  assign ring_in_rdy  = rst && w_slot_free && !w_yield;

  assign w_fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign w_head        = fifo_mem_q[rd_ptr_q[c_addr_w-1:0]];
  assign w_head_local  = !w_fifo_empty && (w_head[PKT_W-2 -: 2] == c_node);
  assign w_head_remote = !w_fifo_empty && (w_head[PKT_W-2 -: 2] != c_node);

  assign w_ring_acc     = ring_in[PKT_W-1] && ring_in_rdy;
  assign w_ring_deliver = w_ring_acc && (ring_in[PKT_W-2 -: 2] == c_node);
  assign w_ring_load    = w_ring_acc && (ring_in[PKT_W-2 -: 2] != c_node);

  // Ring traffic has priority for both pu_rx and the slot; the local head waits.
  assign w_head_deliver = w_head_local && !w_ring_deliver;
  assign w_head_inject  = w_head_remote && w_slot_free && !w_ring_load;
  assign w_pop          = w_head_deliver || w_head_inject;
  assign w_push         = pu_tx[PKT_W-1] && (!fifo_full_q || w_pop);

  always_comb begin
    pu_rx_d = '0;
    if (w_ring_deliver) begin
      pu_rx_d = ring_in;
    end else if (w_head_deliver) begin
      pu_rx_d = w_head;
    end

    ring_out_d = ring_out_q;
    if (w_ring_load) begin
      ring_out_d = ring_in;
    end else if (w_head_inject) begin
      ring_out_d = w_head;
    end else if (ring_out_rdy) begin
      ring_out_d = '0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
    end
    fifo_full_d = (wr_ptr_d[c_ptr_w-1] != rd_ptr_d[c_ptr_w-1]) &&
                  (wr_ptr_d[c_addr_w-1:0] == rd_ptr_d[c_addr_w-1:0]);
  end

  // The yield cycle always ends the starvation window, even if the slot stayed busy.
  always_comb begin
    starve_d = starve_q;
    if (w_yield || w_head_inject || w_fifo_empty) begin
      starve_d = '0;
    end else if (w_ring_load && w_head_remote) begin
      starve_d = starve_q + c_starve_w'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pu_rx_q     <= '0;
      ring_out_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_full_q <= 1'b0;
      starve_q    <= '0;
    end else begin
      pu_rx_q     <= pu_rx_d;
      ring_out_q  <= ring_out_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_full_q <= fifo_full_d;
      starve_q    <= starve_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_mem_q[wr_ptr_q[c_addr_w-1:0]] <= pu_tx;
    end
  end

  assign pu_rx     = pu_rx_q;
  assign ring_out  = ring_out_q;
  assign fifo_full = fifo_full_q;

`ifdef RING_DROP_CNT_EN
  logic       w_drop;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign w_drop = pu_tx[PKT_W-1] && !w_push;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (w_drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ring_node.sv
`default_nettype none
// =====================================================================
// Module   : tb_ring_node
// Purpose  : Directed and random stimulus for ring_node (NODE=1) checked
//            against a queue-based packet model.
// Revision : 1.0  initial release
// =====================================================================
module tb_ring_node;

  localparam int PW    = 20;
  localparam int NODE  = 1;
  localparam int DEPTH = 4;
  localparam int SL    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] pu_tx = '0;
  logic [PW-1:0] ring_in = '0;
  logic          ring_out_rdy = 1'b1;
  logic [PW-1:0] pu_rx;
  logic [PW-1:0] ring_out;
  logic          ring_in_rdy;
  logic          fifo_full;
`ifdef RING_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: packets as whole words, FIFO as a queue.
  logic [PW-1:0] mq[$];
  logic [PW-1:0] m_slot = '0;
  logic [PW-1:0] m_rx   = '0;
  int            m_starve = 0;
  int            m_drop   = 0;
  bit            m_full   = 1'b0;

  always #5 clk = ~clk;

  ring_node #(
    .NODE      (NODE),
    .PKT_W     (PW),
    .FIFO_DEPTH(DEPTH),
    .STARVE_LIM(SL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pu_tx       (pu_tx),
    .pu_rx       (pu_rx),
    .ring_in     (ring_in),
    .ring_in_rdy (ring_in_rdy),
    .ring_out    (ring_out),
    .ring_out_rdy(ring_out_rdy),
    .fifo_full   (fifo_full)
`ifdef RING_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  function automatic logic [PW-1:0] mk(input logic [1:0] d, input logic [16:0] p);
    return {1'b1, d, p};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_rdy(input bit ordy);
    return (!m_slot[PW-1] || ordy) && (m_starve != SL);
  endfunction

  task automatic m_reset();
    mq.delete();
    m_slot   = '0;
    m_rx     = '0;
    m_starve = 0;
    m_drop   = 0;
    m_full   = 1'b0;
  endtask

  // One clock: apply inputs, check readiness, advance the model, check registered outputs.
  task automatic step(input logic [PW-1:0] tx, input logic [PW-1:0] rin, input bit ordy,
                      input string tag);
    bit sf, yld, rdy, acc, rdel, rload, have, hloc, ldel, linj, push;
    logic [PW-1:0] head;
    pu_tx = tx; ring_in = rin; ring_out_rdy = ordy;
    #1;
    sf   = !m_slot[PW-1] || ordy;
    yld  = (m_starve == SL);
    rdy  = sf && !yld;
    chk({tag, ".rdy"}, 32'(ring_in_rdy), 32'(rdy));
    acc   = rin[PW-1] && rdy;
    rdel  = acc && (rin[PW-2 -: 2] == NODE);
    rload = acc && !rdel;
    have  = (mq.size() > 0);
    head  = have ? mq[0] : '0;
    hloc  = have && (head[PW-2 -: 2] == NODE);
    ldel  = hloc && !rdel;
    linj  = have && !hloc && sf && !rload;
    push  = tx[PW-1] && ((mq.size() < DEPTH) || ldel || linj);
    m_rx  = rdel ? rin : (ldel ? head : '0);
    if (rload)     m_slot = rin;
    else if (linj) m_slot = head;
    else if (ordy) m_slot = '0;
    if (yld || linj || !have)   m_starve = 0;
    else if (rload && !hloc)    m_starve = m_starve + 1;
    if (ldel || linj) void'(mq.pop_front());
    if (push) mq.push_back(tx);
    else if (tx[PW-1] && m_drop < 255) m_drop++;
    m_full = (mq.size() == DEPTH);
    @(posedge clk); #1;
    chk({tag, ".pu_rx"}, 32'(pu_rx), 32'(m_rx));
    chk({tag, ".ring_out"}, 32'(ring_out), 32'(m_slot));
    chk({tag, ".fifo_full"}, 32'(fifo_full), 32'(m_full));
`ifdef RING_DROP_CNT_EN
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  // Asserts reset asynchronously (callers sit mid-cycle) and releases on a falling edge.
  task automatic do_reset(input string tag);
    pu_tx = '0; ring_in = '0; ring_out_rdy = 1'b1;
    rst = 1'b0;
    #1;
    chk({tag, ".pu_rx"}, 32'(pu_rx), 32'h0);
    chk({tag, ".ring_out"}, 32'(ring_out), 32'h0);
    chk({tag, ".fifo_full"}, 32'(fifo_full), 32'h0);
    chk({tag, ".rdy"}, 32'(ring_in_rdy), 32'h0);
`ifdef RING_DROP_CNT_EN
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'h0);
`endif
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int seq;
    int yield_at;
    bit rdy_now;
    logic [PW-1:0] tx, rin;

    #1;
    do_reset("rst0");

    // Local packet to a remote node: FIFO push, then slot load.
    step(mk(2'd3, 17'h005A5), '0, 1'b1, "t1a");
    chk("t1.out_early", 32'(ring_out), 32'h0);
    step('0, '0, 1'b1, "t1b");
    chk("t1.out", 32'(ring_out), 32'(mk(2'd3, 17'h005A5)));
    chk("t1.rx_quiet", 32'(pu_rx), 32'h0);
    step('0, '0, 1'b1, "t1c");

    // Ring packet for this node: one-cycle pulse on pu_rx.
    step('0, mk(2'd1, 17'h00123), 1'b1, "t2a");
    chk("t2.rx", 32'(pu_rx), 32'(mk(2'd1, 17'h00123)));
    step('0, '0, 1'b1, "t2b");
    chk("t2.rx_clear", 32'(pu_rx), 32'h0);

    // Ring and local head both target this node in the same cycle.
    step(mk(2'd1, 17'h000AA), '0, 1'b1, "t3a");
    step('0, mk(2'd1, 17'h000BB), 1'b1, "t3b");
    chk("t3.rx_ring", 32'(pu_rx), 32'(mk(2'd1, 17'h000BB)));
    step('0, '0, 1'b1, "t3c");
    chk("t3.rx_local", 32'(pu_rx), 32'(mk(2'd1, 17'h000AA)));
    step('0, '0, 1'b1, "t3d");

    // Downstream stall: slot stable, ring blocked, FIFO fills and the fifth push drops.
    step('0, mk(2'd2, 17'h00222), 1'b0, "t4a");
    for (int i = 0; i < 10; i++) begin
      tx = (i < 5) ? mk(2'd3, 17'(32'h300 + i)) : '0;
      step(tx, mk(2'd2, 17'h002FF), 1'b0, "t4s");
      chk("t4.stable", 32'(ring_out), 32'(mk(2'd2, 17'h00222)));
      chk("t4.blocked", 32'(ring_in_rdy), 32'h0);
    end
    chk("t4.full", 32'(fifo_full), 32'h1);
`ifdef RING_DROP_CNT_EN
    chk("t4.drops", 32'(drop_cnt), 32'h1);
`endif
    for (int k = 0; k < 4; k++) begin
      step('0, '0, 1'b1, "t4d");
      chk("t4.drain", 32'(ring_out), 32'(mk(2'd3, 17'(32'h300 + k))));
    end
    step('0, '0, 1'b1, "t4e");
    chk("t4.empty_out", 32'(ring_out), 32'h0);
    chk("t4.not_full", 32'(fifo_full), 32'h0);

    // Starvation: continuous forwarding traffic with one waiting local packet.
    seq = 0;
    yield_at = -1;
    for (int c = 0; c < 8; c++) begin
      rin = mk(2'd2, 17'(32'h400 + seq));
      tx  = (c == 0) ? mk(2'd3, 17'h005AA) : '0;
      rdy_now = m_rdy(1'b1);
      step(tx, rin, 1'b1, "t5");
      if (rdy_now) seq++;
      else if (yield_at < 0) begin
        yield_at = c;
        chk("t5.inject", 32'(ring_out), 32'(mk(2'd3, 17'h005AA)));
      end
    end
    chk("t5.yield_cycle", 32'(yield_at), 32'd5);
    repeat (2) step('0, '0, 1'b1, "t5z");

    // Asynchronous reset with the slot and FIFO occupied.
    step(mk(2'd3, 17'h006A1), mk(2'd2, 17'h006B0), 1'b0, "t6a");
    step(mk(2'd3, 17'h006A2), '0, 1'b0, "t6b");
    #3;
    do_reset("t6rst");
    for (int k = 0; k < 4; k++) begin
      step('0, '0, 1'b1, "t6c");
      chk("t6.no_stale_out", 32'(ring_out), 32'h0);
      chk("t6.no_stale_rx", 32'(pu_rx), 32'h0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      tx  = ($urandom_range(0, 2) == 0)
          ? mk(2'($urandom_range(0, 3)), 17'($urandom)) : '0;
      rin = ($urandom_range(0, 1) == 0)
          ? mk(2'($urandom_range(0, 3)), 17'($urandom)) : '0;
      step(tx, rin, ($urandom_range(0, 3) != 0), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
